cnn12_buf_ctrl: RTL and testbench

Sequencer for the four-channel conv1→conv2 inter-layer BRAM buffer.
- Fill phase: captures one full conv1 output feature map, generating the 1-based write address and the write enables.
- Drain phase: generates conv2 K×K sliding-window read addresses, shared by all four channel BRAMs, under a ready handshake from conv2.
- Tags returned read data with a valid flag, window-first/last markers and a frame-done pulse.

---
 rtl/cnn12_buf_if.sv | 42 ++++
 rtl/cnn12_buf_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_cnn12_buf_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn12_buf_if.sv
// Handshake/bus bundle between conv1/conv2 logic and the inter-layer buffer sequencer.
// stall_cnt is present only when CNN12_BUF_PERF_EN is defined.
interface cnn12_buf_if #(
  parameter int WADDR_W = 12,
  parameter int RADDR_W = 16
);
  logic               frame_start;
  logic               pix_valid;
  logic               rd_ready;
  logic               write_start;
  logic               write_valid;
  logic [WADDR_W-1:0] writeaddr1;
  logic               read_start;
  logic [RADDR_W-1:0] readaddr;
  logic               rd_data_valid;
  logic               win_first;
  logic               win_last;
  logic               frame_done;
  logic               busy;
  logic               overflow_err;
`ifdef CNN12_BUF_PERF_EN
  logic [31:0]        stall_cnt;
`endif

  modport master (
    output frame_start, pix_valid, rd_ready,
`ifdef CNN12_BUF_PERF_EN
    input  stall_cnt,
`endif
    input  write_start, write_valid, writeaddr1, read_start, readaddr,
           rd_data_valid, win_first, win_last, frame_done, busy, overflow_err
  );

  modport slave (
    input  frame_start, pix_valid, rd_ready,
`ifdef CNN12_BUF_PERF_EN
    output stall_cnt,
`endif
    output write_start, write_valid, writeaddr1, read_start, readaddr,
           rd_data_valid, win_first, win_last, frame_done, busy, overflow_err
  );
endinterface

// File: rtl/cnn12_buf_ctrl.sv
// Fill/drain sequencer for the four-channel conv1->conv2 BRAM buffer.
// Define CNN12_BUF_PERF_EN to add the DRAIN stall counter (bus.stall_cnt).
module cnn12_buf_ctrl #(
  parameter int FM_W    = 24,
  parameter int FM_H    = 24,
  parameter int K       = 3,
  parameter int STRIDE  = 1,
  parameter int WADDR_W = 12,
  parameter int RADDR_W = 16,
  parameter int RD_LAT  = 1
) (
  input  logic       clk,
  input  logic       global_rst,
  cnn12_buf_if.slave bus
);

  localparam int NPIX = FM_W * FM_H;
  localparam int OW   = (FM_W - K) / STRIDE + 1;
  localparam int OH   = (FM_H - K) / STRIDE + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic [WADDR_W-1:0] PIX_LAST = WADDR_W'(NPIX - 1);
  localparam logic [RADDR_W-1:0] R_LAST   = RADDR_W'(OH - 1);
  localparam logic [RADDR_W-1:0] C_LAST   = RADDR_W'(OW - 1);
  localparam logic [RADDR_W-1:0] K_LAST   = RADDR_W'(K - 1);
  localparam logic [RADDR_W-1:0] STRIDE_R = RADDR_W'(STRIDE);
  localparam logic [RADDR_W-1:0] FM_W_R   = RADDR_W'(FM_W);
  localparam logic [RD_LAT-1:0]  PIPE_TAIL_ONLY = RD_LAT'(1) << (RD_LAT - 1);

  logic [1:0]         state_reg, state_next;
  logic [WADDR_W-1:0] pix_cnt_reg, pix_cnt_next;
  logic [WADDR_W-1:0] writeaddr1_reg, writeaddr1_next;
  logic               write_start_reg, write_start_next;
  logic               write_valid_reg, write_valid_next;
  logic               read_start_reg, read_start_next;
  logic [RADDR_W-1:0] readaddr_reg, readaddr_next;
  logic               frame_done_reg, frame_done_next;
  logic               busy_reg, busy_next;
  logic               overflow_err_reg, overflow_err_next;
  logic [RADDR_W-1:0] r_reg, r_next, c_reg, c_next;
  logic [RADDR_W-1:0] ky_reg, ky_next, kx_reg, kx_next;
  logic [RADDR_W-1:0] r_adv, c_adv, ky_adv, kx_adv;

  logic               issue;
  logic               tap_first, tap_last, tap_final;
  logic [RD_LAT-1:0]  pipe_valid, pipe_first, pipe_last;

  function automatic logic [RADDR_W-1:0] tap_addr(
    input logic [RADDR_W-1:0] r,
    input logic [RADDR_W-1:0] c,
    input logic [RADDR_W-1:0] ky,
    input logic [RADDR_W-1:0] kx
  );
    return (r * STRIDE_R + ky) * FM_W_R + c * STRIDE_R + kx;
  endfunction

  assign tap_first = (ky_reg == '0) && (kx_reg == '0);
  assign tap_last  = (ky_reg == K_LAST) && (kx_reg == K_LAST);
  assign tap_final = tap_last && (r_reg == R_LAST) && (c_reg == C_LAST);

  // Window counters after one issued tap; kx is innermost, r outermost.
  always_comb begin
    r_adv  = r_reg;
    c_adv  = c_reg;
    ky_adv = ky_reg;
    kx_adv = kx_reg;
    if (kx_reg != K_LAST) begin
      kx_adv = kx_reg + RADDR_W'(1);
    end else begin
      kx_adv = '0;
      if (ky_reg != K_LAST) begin
        ky_adv = ky_reg + RADDR_W'(1);
      end else begin
        ky_adv = '0;
        if (c_reg != C_LAST) begin
          c_adv = c_reg + RADDR_W'(1);
        end else begin
          c_adv = '0;
          r_adv = r_reg + RADDR_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_next        = state_reg;
    pix_cnt_next      = pix_cnt_reg;
    writeaddr1_next   = writeaddr1_reg;
    write_start_next  = write_start_reg;
    write_valid_next  = 1'b0;
    read_start_next   = read_start_reg;
    readaddr_next     = readaddr_reg;
    frame_done_next   = 1'b0;
    overflow_err_next = overflow_err_reg;
    r_next            = r_reg;
    c_next            = c_reg;
    ky_next           = ky_reg;
    kx_next           = kx_reg;
    issue             = 1'b0;

    if (bus.pix_valid && (state_reg != S_FILL)) begin
      overflow_err_next = 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (bus.frame_start) begin
          state_next       = S_FILL;
          write_start_next = 1'b1;
          pix_cnt_next     = '0;
          r_next           = '0;
          c_next           = '0;
          ky_next          = '0;
          kx_next          = '0;
        end
      end
      S_FILL: begin
        if (bus.pix_valid) begin
          write_valid_next = 1'b1;
          writeaddr1_next  = pix_cnt_reg + WADDR_W'(1);
          pix_cnt_next     = pix_cnt_reg + WADDR_W'(1);
          if (pix_cnt_reg == PIX_LAST) begin
            state_next       = S_DRAIN;
            pix_cnt_next     = '0;
            write_start_next = 1'b0;
            read_start_next  = 1'b1;
            readaddr_next    = '0;
          end
        end
      end
      S_DRAIN: begin
        if (bus.rd_ready) begin
          issue = 1'b1;
          if (tap_final) begin
            state_next = S_FLUSH;
          end else begin
            r_next        = r_adv;
            c_next        = c_adv;
            ky_next       = ky_adv;
            kx_next       = kx_adv;
            readaddr_next = tap_addr(r_adv, c_adv, ky_adv, kx_adv);
          end
        end
      end
      S_FLUSH: begin
        // frame_done is raised while still in FLUSH; the state returns to IDLE after it.
        if (frame_done_reg) begin
          state_next    = S_IDLE;
          readaddr_next = '0;
          r_next        = '0;
          c_next        = '0;
          ky_next       = '0;
          kx_next       = '0;
        end else if (pipe_valid == PIPE_TAIL_ONLY) begin
          frame_done_next = 1'b1;
          read_start_next = 1'b0;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!global_rst) begin
      state_reg        <= S_IDLE;
      pix_cnt_reg      <= '0;
      writeaddr1_reg   <= '0;
      write_start_reg  <= 1'b0;
      write_valid_reg  <= 1'b0;
      read_start_reg   <= 1'b0;
      readaddr_reg     <= '0;
      frame_done_reg   <= 1'b0;
      busy_reg         <= 1'b0;
      overflow_err_reg <= 1'b0;
      r_reg            <= '0;
      c_reg            <= '0;
      ky_reg           <= '0;
      kx_reg           <= '0;
    end else begin
      state_reg        <= state_next;
      pix_cnt_reg      <= pix_cnt_next;
      writeaddr1_reg   <= writeaddr1_next;
      write_start_reg  <= write_start_next;
      write_valid_reg  <= write_valid_next;
      read_start_reg   <= read_start_next;
      readaddr_reg     <= readaddr_next;
      frame_done_reg   <= frame_done_next;
      busy_reg         <= busy_next;
      overflow_err_reg <= overflow_err_next;
      r_reg            <= r_next;
      c_reg            <= c_next;
      ky_reg           <= ky_next;
      kx_reg           <= kx_next;
    end
  end

  // Tap tags travel alongside the BRAM read so they line up with dout.
  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
    logic v_reg, f_reg, l_reg;
    logic v_in, f_in, l_in;
    if (gi == 0) begin : g_head
      assign v_in = issue;
      assign f_in = issue & tap_first;
      assign l_in = issue & tap_last;
    end else begin : g_tail
      assign v_in = pipe_valid[gi-1];
      assign f_in = pipe_first[gi-1];
      assign l_in = pipe_last[gi-1];
    end
    always_ff @(posedge clk) begin
      if (!global_rst) begin
        v_reg <= 1'b0;
        f_reg <= 1'b0;
        l_reg <= 1'b0;
      end else begin
        v_reg <= v_in;
        f_reg <= f_in;
        l_reg <= l_in;
      end
    end
    assign pipe_valid[gi] = v_reg;
    assign pipe_first[gi] = f_reg;
    assign pipe_last[gi]  = l_reg;
  end

`ifdef CNN12_BUF_PERF_EN
  logic [31:0] stall_cnt_reg;
  always_ff @(posedge clk) begin
    if (!global_rst) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg == S_IDLE) && bus.frame_start) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg == S_DRAIN) && !bus.rd_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end
  assign bus.stall_cnt = stall_cnt_reg;
`endif

  assign bus.write_start   = write_start_reg;
  assign bus.write_valid   = write_valid_reg;
  assign bus.writeaddr1    = writeaddr1_reg;
  assign bus.read_start    = read_start_reg;
  assign bus.readaddr      = readaddr_reg;
  assign bus.rd_data_valid = pipe_valid[RD_LAT-1];
  assign bus.win_first     = pipe_first[RD_LAT-1];
  assign bus.win_last      = pipe_last[RD_LAT-1];
  assign bus.frame_done    = frame_done_reg;
  assign bus.busy          = busy_reg;
  assign bus.overflow_err  = overflow_err_reg;

endmodule

// File: tb/tb_cnn12_buf_ctrl.sv
// Self-checking bench for cnn12_buf_ctrl: cycle vector table plus scoreboarded full frames.
module tb_cnn12_buf_ctrl;
  localparam int FM_W    = 24;
  localparam int FM_H    = 24;
  localparam int K       = 3;
  localparam int STRIDE  = 1;
  localparam int WADDR_W = 12;
  localparam int RADDR_W = 16;
  localparam int RD_LAT  = 1;
  localparam int NPIX    = FM_W * FM_H;
  localparam int OW      = (FM_W - K) / STRIDE + 1;
  localparam int OH      = (FM_H - K) / STRIDE + 1;
  localparam int NTAP    = OW * OH * K * K;

  logic clk = 1'b0;
  logic global_rst = 1'b0;
  always #5 clk = ~clk;

  cnn12_buf_if #(.WADDR_W(WADDR_W), .RADDR_W(RADDR_W)) bus();

  cnn12_buf_ctrl #(
    .FM_W(FM_W), .FM_H(FM_H), .K(K), .STRIDE(STRIDE),
    .WADDR_W(WADDR_W), .RADDR_W(RADDR_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .global_rst(global_rst),
    .bus(bus)
  );

  typedef struct {
    logic               rst_n;
    logic               fs;
    logic               pv;
    logic               ws;
    logic               wv;
    logic [WADDR_W-1:0] wa;
    logic               busy;
    logic               ov;
  } vec_t;

  typedef struct { int due; int addr; } wr_t;
  typedef struct { int due; logic first; logic last; } tap_t;

  wr_t  wr_q[$];
  tap_t tap_q[$];
  int   rd_q[$];
  int   cyc = 0;
  int   done_due = -1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   wr_seen, rdv_seen, done_seen;
  bit   sb_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon();
    wr_t  w;
    tap_t t;
    if (bus.write_valid) begin
      wr_seen++;
      if (wr_q.size() == 0) chk("unexpected_write", bus.write_valid, 0);
      else begin
        w = wr_q.pop_front();
        chk("write_addr", bus.writeaddr1, w.addr);
        chk("write_time", cyc, w.due);
      end
    end else if (wr_q.size() != 0 && wr_q[0].due <= cyc) begin
      chk("write_missing", bus.write_valid, 1);
      void'(wr_q.pop_front());
    end
    if (bus.rd_data_valid) begin
      rdv_seen++;
      if (tap_q.size() == 0) chk("unexpected_rdv", bus.rd_data_valid, 0);
      else begin
        t = tap_q.pop_front();
        chk("rdv_time", cyc, t.due);
        chk("win_first", bus.win_first, t.first);
        chk("win_last", bus.win_last, t.last);
      end
    end else if (tap_q.size() != 0 && tap_q[0].due <= cyc) begin
      chk("rdv_missing", bus.rd_data_valid, 1);
      void'(tap_q.pop_front());
    end
    if (bus.frame_done) begin
      done_seen++;
      chk("frame_done_time", cyc, done_due);
      done_due = -1;
    end else if (done_due >= 0 && cyc >= done_due) begin
      chk("frame_done_missing", bus.frame_done, 1);
      done_due = -1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (sb_on) mon();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_write_start"}, bus.write_start, 0);
    chk({tag, "_write_valid"}, bus.write_valid, 0);
    chk({tag, "_writeaddr1"}, bus.writeaddr1, 0);
    chk({tag, "_read_start"}, bus.read_start, 0);
    chk({tag, "_readaddr"}, bus.readaddr, 0);
    chk({tag, "_rd_data_valid"}, bus.rd_data_valid, 0);
    chk({tag, "_win_first"}, bus.win_first, 0);
    chk({tag, "_win_last"}, bus.win_last, 0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_overflow_err"}, bus.overflow_err, 0);
`ifdef CNN12_BUF_PERF_EN
    chk({tag, "_stall_cnt"}, bus.stall_cnt, 0);
`endif
  endtask

  task automatic start_frame();
    wr_seen = 0;
    rdv_seen = 0;
    done_seen = 0;
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    chk("start_write_start", bus.write_start, 1);
    chk("start_busy", bus.busy, 1);
  endtask

  task automatic fill(input int density);
    int  n;
    bit  pv;
    n = 0;
    while (n < NPIX) begin
      chk("no_early_drain", bus.read_start, 0);
      pv = (density >= 100) || ($urandom_range(99) < density);
      bus.pix_valid = pv;
      if (pv) begin
        wr_q.push_back('{cyc + 1, n + 1});
        n++;
      end
      step();
    end
    bus.pix_valid = 1'b0;
    chk("drain_read_start", bus.read_start, 1);
    chk("drain_write_start", bus.write_start, 0);
    chk("write_count", wr_seen, NPIX);
  endtask

  task automatic drain(input int mode, input int pv_at, input int stop_after, output int lows);
    int   issued, i, last_first, last_addr;
    int   obs[10];
    int   exp_first[10];
    bit   rdy;
    exp_first = '{0, 1, 2, 24, 25, 26, 48, 49, 50, 1};
    rd_q.delete();
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++)
            rd_q.push_back((r * STRIDE + ky) * FM_W + c * STRIDE + kx);
    issued = 0; i = 0; lows = 0; last_first = -1; last_addr = -1;
    while (rd_q.size() != 0 && issued < stop_after) begin
      rdy = (mode == 0) || ((i % 4) == 0) || ((i % 4) == 3);
      chk("read_start_hi", bus.read_start, 1);
      chk("read_addr", bus.readaddr, rd_q[0]);
      bus.rd_ready  = rdy;
      bus.pix_valid = (i == pv_at);
      if (rdy) begin
        if (issued < 10) obs[issued] = int'(bus.readaddr);
        if (issued == NTAP - K * K) last_first = int'(bus.readaddr);
        if (issued == NTAP - 1) last_addr = int'(bus.readaddr);
        tap_q.push_back('{cyc + RD_LAT, (issued % (K * K)) == 0, (issued % (K * K)) == K * K - 1});
        void'(rd_q.pop_front());
        issued++;
        if (rd_q.size() == 0) done_due = cyc + RD_LAT + 1;
      end else begin
        lows++;
      end
      i++;
      step();
    end
    bus.rd_ready  = 1'b0;
    bus.pix_valid = 1'b0;
    if (issued == NTAP) begin
      for (int k = 0; k < 10; k++) chk($sformatf("window_addr%0d", k), obs[k], exp_first[k]);
      chk("last_window_first_addr", last_first, 525);
      chk("last_addr", last_addr, 575);
      for (int g = 0; g < RD_LAT + 4 && (done_due >= 0 || tap_q.size() != 0); g++) step();
      chk("rdv_count", rdv_seen, NTAP);
      chk("frame_done_count", done_seen, 1);
      step();
      chk("idle_busy", bus.busy, 0);
      chk("idle_read_start", bus.read_start, 0);
      chk("idle_frame_done", bus.frame_done, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[14];
    int   lows;
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'd1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'd2, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'd3, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd3, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'd0, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'd1, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0};

    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.rd_ready    = 1'b0;
    repeat (3) step();
    chk_zero("reset");
    global_rst = 1'b1;

    // Cycle-level vectors: FILL start, gaps, ignored frame_start, reset and IDLE overflow.
    for (int v = 0; v < 14; v++) begin
      global_rst      = vecs[v].rst_n;
      bus.frame_start = vecs[v].fs;
      bus.pix_valid   = vecs[v].pv;
      step();
      chk($sformatf("vec%0d_write_start", v), bus.write_start, vecs[v].ws);
      chk($sformatf("vec%0d_write_valid", v), bus.write_valid, vecs[v].wv);
      chk($sformatf("vec%0d_writeaddr1", v), bus.writeaddr1, vecs[v].wa);
      chk($sformatf("vec%0d_busy", v), bus.busy, vecs[v].busy);
      chk($sformatf("vec%0d_overflow_err", v), bus.overflow_err, vecs[v].ov);
    end
    global_rst      = 1'b1;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    sb_on = 1'b1;

    // Back-to-back fill, rd_ready held high.
    start_frame();
    fill(100);
    drain(0, -1, NTAP, lows);
    chk("frameA_overflow_clear", bus.overflow_err, 0);

    // Random-gap fill, 1,0,0,1 ready pattern, stray pix_valid in DRAIN.
    start_frame();
    fill(50);
    drain(1, 5, NTAP, lows);
`ifdef CNN12_BUF_PERF_EN
    chk("stall_cnt", bus.stall_cnt, lows);
`endif
    chk("overflow_after_drain_pulse", bus.overflow_err, 1);

    // Sticky error across the next frame, then reset in the middle of DRAIN.
    start_frame();
    chk("overflow_sticky_next_frame", bus.overflow_err, 1);
`ifdef CNN12_BUF_PERF_EN
    chk("stall_cnt_cleared", bus.stall_cnt, 0);
`endif
    fill(100);
    drain(0, -1, 40, lows);
    sb_on = 1'b0;
    global_rst = 1'b0;
    step();
    global_rst = 1'b1;
    chk_zero("rst_mid_drain");
    wr_q.delete();
    tap_q.delete();
    done_due = -1;
    sb_on = 1'b1;

    // Clean restart after the mid-frame reset.
    start_frame();
    fill(100);
    drain(0, -1, NTAP, lows);
    chk("restart_overflow_clear", bus.overflow_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
